alu_slice_seq: RTL and testbench

ALU_SLICE_SEQ -- requirements
Module: alu_slice_seq

---
 rtl/alu_slice_seq.sv | 124 ++++++++++++
 tb/tb_alu_slice_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_slice_seq.sv
// rtl/alu_slice_seq.sv - 16-bit operation sequenced over an external 4-bit ALU, one slice per cycle
// Optional zero flag output enabled by defining ALU_SLICE_SEQ_ZERO_EN.
module alu_slice_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op_s,
    input  logic        op_m,
    input  logic        op_cin,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic [3:0]  alu_s,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_m,
    output logic        alu_cn,
    input  logic [3:0]  alu_f,
    input  logic        alu_cn4,
    input  logic        alu_aeqb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cout,
`ifdef ALU_SLICE_SEQ_ZERO_EN
    output logic        zero,
`endif
    output logic        aeqb
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT       state, stateNext;
    logic [1:0]  idx;
    logic [15:0] latA, latB;
    logic [3:0]  latS;
    logic        latM;
    logic        carry;
    logic        aeqbAcc;
    logic [15:0] resultNext;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (idx == 2'd3) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // ALU inputs stay quiet outside RUN so the shared ALU sees no stray activity
    always_comb begin
        alu_s  = 4'd0;
        alu_a  = 4'd0;
        alu_b  = 4'd0;
        alu_m  = 1'b0;
        alu_cn = 1'b0;
        if (state == RUN) begin
            alu_s  = latS;
            alu_a  = latA[{idx, 2'b00} +: 4];
            alu_b  = latB[{idx, 2'b00} +: 4];
            alu_m  = latM;
            alu_cn = carry;
        end
    end

    always_comb begin
        resultNext = result;
        resultNext[{idx, 2'b00} +: 4] = alu_f;
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            latA    <= 16'd0;
            latB    <= 16'd0;
            latS    <= 4'd0;
            latM    <= 1'b0;
            carry   <= 1'b0;
            aeqbAcc <= 1'b0;
            result  <= 16'd0;
            cout    <= 1'b0;
            aeqb    <= 1'b0;
`ifdef ALU_SLICE_SEQ_ZERO_EN
            zero    <= 1'b0;
`endif
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (start) begin
                        latA    <= opa;
                        latB    <= opb;
                        latS    <= op_s;
                        latM    <= op_m;
                        carry   <= op_cin;
                        idx     <= 2'd0;
                        aeqbAcc <= 1'b1;
                    end
                end
                RUN: begin
                    // Carry chains through in logic mode too; the ALU ignores it there
                    result  <= resultNext;
                    carry   <= alu_cn4;
                    aeqbAcc <= aeqbAcc & alu_aeqb;
                    idx     <= idx + 2'd1;
`ifdef ALU_SLICE_SEQ_ZERO_EN
                    zero    <= (resultNext == 16'h0000);
`endif
                    if (idx == 2'd3) begin
                        cout <= alu_cn4;
                        aeqb <= aeqbAcc & alu_aeqb;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_slice_seq.sv
// tb/tb_alu_slice_seq.sv - scoreboard bench for alu_slice_seq with a behavioural 4-bit ALU on the alu_* ports
module tb_alu_slice_seq;

    logic        clk = 1'b0;
    logic        rst, start, op_m, op_cin;
    logic [3:0]  op_s;
    logic [15:0] opa, opb;
    logic [3:0]  alu_s, alu_a, alu_b, alu_f;
    logic        alu_m, alu_cn, alu_cn4, alu_aeqb;
    logic        busy, done, cout, aeqb;
    logic [15:0] result;
`ifdef ALU_SLICE_SEQ_ZERO_EN
    logic        zero;
`endif

    always #5 clk = ~clk;

    alu_slice_seq dut (
        .clk(clk), .rst(rst), .start(start), .op_s(op_s), .op_m(op_m),
        .op_cin(op_cin), .opa(opa), .opb(opb),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_cn(alu_cn),
        .alu_f(alu_f), .alu_cn4(alu_cn4), .alu_aeqb(alu_aeqb),
        .busy(busy), .done(done), .result(result), .cout(cout),
`ifdef ALU_SLICE_SEQ_ZERO_EN
        .zero(zero),
`endif
        .aeqb(aeqb)
    );

    // Active-high 4-bit ALU: Cn=1 means no carry in, Cn4=0 means carry out
    logic [3:0] t1, t2;
    logic [4:0] sum;
    always_comb begin
        t1 = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        t2 = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
        sum = {1'b0, t1} + {1'b0, t2} + {4'd0, ~alu_cn};
        alu_f = alu_m ? ~(t1 ^ t2) : sum[3:0];
        alu_cn4 = ~sum[4];
        alu_aeqb = &alu_f;
    end

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        e;
        logic        z;
    } expT;

    expT sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  doneSeen = 0;
    int  pushed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            expT e;
            doneSeen++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                e = sbq.pop_front();
                check("result", {16'd0, result}, {16'd0, e.r});
                check("cout", {31'd0, cout}, {31'd0, e.c});
                check("aeqb", {31'd0, aeqb}, {31'd0, e.e});
`ifdef ALU_SLICE_SEQ_ZERO_EN
                check("zero", {31'd0, zero}, {31'd0, e.z});
`endif
            end
        end
    end

    task automatic doOp(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cin, input logic [15:0] er, input logic ec,
                        input logic ee, input logic ez, input bit spam);
        expT e;
        int lat;
        @(negedge clk);
        opa = a; opb = b; op_s = s; op_m = m; op_cin = cin; start = 1'b1;
        e.r = er; e.c = ec; e.e = ee; e.z = ez;
        sbq.push_back(e);
        pushed++;
        @(posedge clk);
        #1;
        if (!spam) start = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("alu_s_run", {28'd0, alu_s}, {28'd0, s});
                check("alu_a_slice0", {28'd0, alu_a}, {28'd0, a[3:0]});
                check("alu_cn_run", {31'd0, alu_cn}, {31'd0, cin});
            end
            if (done) break;
            check("busy_run", {31'd0, busy}, 32'd1);
            if (spam) begin
                opa = ~opa; opb = opb + 16'h1111; op_s = ~op_s; op_cin = ~op_cin;
            end
        end
        start = 1'b0;
        check("latency", lat, 5);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op_s = 4'd0; op_m = 1'b0; op_cin = 1'b0;
        opa = 16'd0; opb = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_aeqb", {31'd0, aeqb}, 32'd0);
        check("rst_alu_a", {28'd0, alu_a}, 32'd0);
`ifdef ALU_SLICE_SEQ_ZERO_EN
        check("rst_zero", {31'd0, zero}, 32'd0);
`endif

        doOp(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);
        doOp(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        doOp(16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0);
        doOp(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        doOp(16'h1234, 16'h1235, 4'b0110, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        doOp(16'h7FFF, 16'h0000, 4'b1001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
        doOp(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b1);

        // Abort at slice 2 with a start coincident with reset
        @(negedge clk);
        opa = 16'hFFFF; opb = 16'h0001; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", {16'd0, result}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_stay_idle", {31'd0, busy}, 32'd0);

        doOp(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("done_count", doneSeen, pushed);
        check("queue_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
